apb_uart_slave: RTL

//  APB3 completer between the APB master (APB_top) and the UART core FIFOs.

---
 rtl/apb_uart_slave.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/apb_uart_slave.sv
// APB3 completer bridging an APB master to the UART TX/RX FIFOs, with status,
// scratch and baud-divisor registers. Stalls on FIFO full/empty, errors on timeout.
module apb_uart_slave #(
    parameter int unsigned ADDR_W    = 5,
    parameter int unsigned DIV_W     = 16,
    parameter int unsigned DIV_RESET = 651,
    parameter int unsigned TIMEOUT   = 16
) (
    input  logic              PCLK,
    input  logic              PRESET,
    input  logic              PSEL,
    input  logic              PENABLE,
    input  logic              PWRITE,
    input  logic [ADDR_W-1:0] PADDR,
    input  logic [31:0]       PWDATA,
    output logic [31:0]       PRDATA,
    output logic              PREADY,
    output logic              PSLVERR,
    output logic [7:0]        w_data,
    output logic              wr_uart,
    input  logic              tx_full,
    input  logic [7:0]        r_data,
    output logic              rd_uart,
    input  logic              rx_empty,
    output logic [DIV_W-1:0]  baud_div
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT + 2);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_WAIT   = 2'd2;

    localparam logic [ADDR_W-1:0] ADDR_TX      = ADDR_W'('h10);
    localparam logic [ADDR_W-1:0] ADDR_RX      = ADDR_W'('h11);
    localparam logic [ADDR_W-1:0] ADDR_SCRATCH = ADDR_W'('h12);
    localparam logic [ADDR_W-1:0] ADDR_STATUS  = ADDR_W'('h14);
    localparam logic [ADDR_W-1:0] ADDR_DIV     = ADDR_W'('h15);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic [31:0]      prdata_q, prdata_d;
    logic             pready_q, pready_d;
    logic             pslverr_q, pslverr_d;
    logic             wr_q, wr_d;
    logic             rd_q, rd_d;
    logic [7:0]       w_data_q, w_data_d;
    logic [31:0]      scratch_q, scratch_d;
    logic [DIV_W-1:0] baud_q, baud_d;
    logic             to_flag_q, to_flag_d;

    logic        setup, is_tx, is_rx, is_scratch, is_status, is_div;
    logic        wr_tx, rd_rx, legal, stall;
    logic [31:0] rd_val;

    always_comb begin
        setup      = PSEL & ~PENABLE;
        is_tx      = (PADDR == ADDR_TX);
        is_rx      = (PADDR == ADDR_RX);
        is_scratch = (PADDR == ADDR_SCRATCH);
        is_status  = (PADDR == ADDR_STATUS);
        is_div     = (PADDR == ADDR_DIV);
        wr_tx      = PWRITE & is_tx;
        rd_rx      = ~PWRITE & is_rx;
        legal      = wr_tx | rd_rx | is_scratch | (is_status & ~PWRITE) | is_div;
        stall      = (wr_tx & tx_full) | (rd_rx & rx_empty);
        cnt_inc    = cnt_q + 1'b1;

        rd_val = 32'h0;
        if (!PWRITE) begin
            if (is_rx)           rd_val = {24'h0, r_data};
            else if (is_scratch) rd_val = scratch_q;
            else if (is_status)  rd_val = {29'h0, to_flag_q, rx_empty, tx_full};
            else if (is_div)     rd_val = 32'(baud_q);
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        prdata_d  = prdata_q;
        pready_d  = pready_q;
        pslverr_d = pslverr_q;
        wr_d      = 1'b0;
        rd_d      = 1'b0;
        w_data_d  = w_data_q;
        scratch_d = scratch_q;
        baud_d    = baud_q;
        to_flag_d = to_flag_q;

        case (state_q)
            ST_IDLE: begin
                pready_d  = 1'b0;
                pslverr_d = 1'b0;
                if (setup) begin
                    if (wr_tx) w_data_d = PWDATA[7:0];
                    if (!legal) begin
                        state_d   = ST_ACCESS;
                        pready_d  = 1'b1;
                        pslverr_d = 1'b1;
                        prdata_d  = 32'h0;
                    end else if (stall) begin
                        if (TIMEOUT == 0) begin
                            state_d   = ST_ACCESS;
                            pready_d  = 1'b1;
                            pslverr_d = 1'b1;
                            prdata_d  = 32'h0;
                            to_flag_d = 1'b1;
                        end else begin
                            state_d = ST_WAIT;
                            cnt_d   = '0;
                        end
                    end else begin
                        state_d  = ST_ACCESS;
                        pready_d = 1'b1;
                        prdata_d = rd_val;
                        wr_d     = wr_tx;
                        rd_d     = rd_rx;
                    end
                end
            end
            ST_WAIT: begin
                if (!PSEL) begin
                    state_d = ST_IDLE;
                end else if (!stall) begin
                    state_d  = ST_ACCESS;
                    pready_d = 1'b1;
                    prdata_d = rd_val;
                    wr_d     = wr_tx;
                    rd_d     = rd_rx;
                end else if (cnt_inc == CNT_W'(TIMEOUT)) begin
                    state_d   = ST_ACCESS;
                    pready_d  = 1'b1;
                    pslverr_d = 1'b1;
                    prdata_d  = 32'h0;
                    to_flag_d = 1'b1;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            ST_ACCESS: begin
                state_d   = ST_IDLE;
                pready_d  = 1'b0;
                pslverr_d = 1'b0;
                // Abandoned or errored transfers leave the registers untouched.
                if (PSEL && !pslverr_q) begin
                    if (PWRITE && is_scratch) scratch_d = PWDATA;
                    if (PWRITE && is_div)     baud_d    = PWDATA[DIV_W-1:0];
                    if (!PWRITE && is_status) to_flag_d = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            prdata_q  <= 32'h0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            wr_q      <= 1'b0;
            rd_q      <= 1'b0;
            w_data_q  <= 8'h0;
            scratch_q <= 32'h0;
            baud_q    <= DIV_W'(DIV_RESET);
            to_flag_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            prdata_q  <= prdata_d;
            pready_q  <= pready_d;
            pslverr_q <= pslverr_d;
            wr_q      <= wr_d;
            rd_q      <= rd_d;
            w_data_q  <= w_data_d;
            scratch_q <= scratch_d;
            baud_q    <= baud_d;
            to_flag_q <= to_flag_d;
        end
    end

    // Pulses are suppressed if the master abandons the transfer in ACCESS.
    assign wr_uart  = wr_q & PSEL;
    assign rd_uart  = rd_q & PSEL;
    assign PRDATA   = prdata_q;
    assign PREADY   = pready_q;
    assign PSLVERR  = pslverr_q;
    assign w_data   = w_data_q;
    assign baud_div = baud_q;

endmodule
